// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic front-end blocks.
package bicubic_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Tag field carried alongside each pixel; stored above the pixel bits
    localparam int TAG_W   = 3;
    localparam int TAG_SOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 2;

endpackage

// File: rtl/bicubic_skid2.sv
// Generic 2-entry valid/ready skid buffer. e0 is always the head and drives
// the output directly, so a push into an empty buffer is visible next cycle.
// count_next is exported so the producer can register its ready early.
module bicubic_skid2 #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count,
    output logic [1:0]   count_next
);

    logic [W-1:0] e0, e1;
    logic         push, pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = e0;

    // Occupancy bookkeeping; a full buffer never accepts, so no overwrite
    always_comb begin
        push       = in_valid && (count != 2'd2);
        pop        = (count != 2'd0) && out_ready;
        count_next = count;
        if (flush)
            count_next = 2'd0;
        else if (push && !pop)
            count_next = count + 2'd1;
        else if (pop && !push)
            count_next = count - 2'd1;
    end

    // Entry storage: pop shifts e1 into the head, push fills the first free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                e0 <= '0;
                e1 <= '0;
            end else begin
                if (pop && count == 2'd2)
                    e0 <= e1;
                if (push) begin
                    if (count == 2'd0 || (count == 2'd1 && pop))
                        e0 <= in_data;
                    else
                        e1 <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/bicubic_frame_seq.sv
// Frame sequencer: admits one WIDTH x HEIGHT frame per start, tags pixels
// with SOF/EOL/EOF, buffers them through a 2-entry skid and waits for the
// core's write-back before reporting frame_done.
module bicubic_frame_seq
    import bicubic_pkg::*;
#(
    parameter int WIDTH  = 960,
    parameter int HEIGHT = 540,
    parameter int DW     = 24,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    input  logic          core_done,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    localparam int            EW       = DW + TAG_W;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(HEIGHT - 1);

    state_t           state, state_next;
    logic [CW-1:0]    col, row;
    logic             done_seen;
    logic             start_go, accept, last_pix, flush;
    logic [TAG_W-1:0] tag_in;
    logic [EW-1:0]    head;
    logic [1:0]       count, count_next;

    // abort outranks everything, including a start in IDLE
    assign start_go = start & ~abort & (state == ST_IDLE);
    assign accept   = s_valid & s_ready & ~abort;
    assign flush    = abort | start_go;
    assign last_pix = accept & (col == COL_LAST) & (row == ROW_LAST);

    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);

    // Tags come from the pre-increment position of the pixel being accepted
    always_comb begin
        tag_in          = '0;
        tag_in[TAG_SOF] = (col == '0) && (row == '0);
        tag_in[TAG_EOL] = (col == COL_LAST);
        tag_in[TAG_EOF] = (col == COL_LAST) && (row == ROW_LAST);
    end

    bicubic_skid2 #(.W(EW)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (accept),
        .in_data    ({tag_in, s_data}),
        .out_valid  (m_valid),
        .out_ready  (m_ready),
        .out_data   (head),
        .count      (count),
        .count_next (count_next)
    );

    assign m_data = head[DW-1:0];
    assign m_sof  = head[DW+TAG_SOF];
    assign m_eol  = head[DW+TAG_EOL];
    assign m_eof  = head[DW+TAG_EOF];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_next = ST_RUN;
                ST_RUN:   if (last_pix) state_next = ST_DRAIN;
                ST_DRAIN: if (count == 2'd0 && (done_seen || core_done))
                              state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Column/row position of the next pixel to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (start_go) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // core_done is only remembered while draining; earlier pulses just flag err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            done_seen <= 1'b0;
        else if (abort || state != ST_DRAIN)
            done_seen <= 1'b0;
        else if (core_done)
            done_seen <= 1'b1;
    end

    // Sticky error: write-back completion reported before the frame was drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (start_go)
            err <= 1'b0;
        else if (!abort && core_done && (state == ST_IDLE || state == ST_RUN))
            err <= 1'b1;
    end

    // Registered source ready: running next cycle with room for one more pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_ready <= 1'b0;
        else        s_ready <= (state_next == ST_RUN) && (count_next <= 2'd1);
    end

endmodule

// File: tb/tb_bicubic_frame_seq.sv
// Scoreboard bench for the frame sequencer on a 4x2 frame.
module tb_bicubic_frame_seq;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int DW   = 24;
    localparam int CW   = 16;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b0, core_done = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, m_valid, m_sof, m_eol, m_eof, busy, frame_done, err;
    logic [DW-1:0] m_data;

    bicubic_frame_seq #(.WIDTH(W), .HEIGHT(H), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .core_done(core_done), .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int            n_chk = 0, n_fail = 0;
    logic [31:0]   q[$];
    int            idx = 0, src_id = 0, fd_cnt = 0, fd_cyc = 0, cyc = 0;
    int            pops = 0, first_pop = 0, last_pop = 0, first_push = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge and predict what the next
    // rising edge transfers (DUT outputs do not depend combinationally on inputs).
    task automatic step(input int sv, input int mr, input int cd, input int st, input int ab);
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        s_valid   = (sv != 0);
        m_ready   = (mr != 0);
        core_done = (cd != 0);
        start     = (st != 0);
        abort     = (ab != 0);
        s_data    = DW'(src_id) ^ 24'hA50000;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (prev_stall) check("hold", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
        prev_stall = m_valid && !m_ready && !abort;
        prev_data  = m_data;
        if (abort) begin
            q.delete();
        end else begin
            if (m_valid && m_ready) begin
                if (q.size() == 0) check("extra_pix", 32'(m_valid), 32'd0);
                else begin
                    e = q.pop_front();
                    check("pix", 32'({m_eof, m_eol, m_sof, m_data}), e);
                end
                pops++;
                if (pops == 1) first_pop = cyc;
                last_pop = cyc;
            end
            if (s_valid && s_ready) begin
                q.push_back(32'({idx == NPIX - 1, idx % W == W - 1, idx == 0, s_data}));
                if (first_push < 0) first_push = cyc;
                idx++;
                src_id++;
            end
            if (start && !busy) begin idx = 0; q.delete(); end
            check("occ", 32'(q.size() <= 2), 32'd1);
        end
    endtask

    // mode 0: full rate; 1: random source, toggling sink; 2: 10-cycle sink stall
    // mid-row; 3: early core_done and a stray start while running
    task automatic run_frame(input int mode);
        int n, stall, cd_cyc;
        int sv, mr, cd, st;
        bit cd_fired, st_fired, stall_chk, err_chk;
        pops = 0; fd_cnt = 0; first_push = -1;
        n = 0; stall = 0; cd_fired = 0; st_fired = 0; stall_chk = 0; err_chk = 0;
        step(0, 1, 0, 1, 0);
        while ((idx < NPIX || q.size() != 0) && n < 300) begin
            n++;
            sv = 1; mr = 1; cd = 0; st = 0;
            case (mode)
                1: begin sv = int'($urandom_range(0, 1)); mr = n % 2; end
                2: if (idx >= 2 && stall < 10) begin mr = 0; stall++; end
                3: begin
                    if (idx == 3 && !cd_fired) begin cd = 1; cd_fired = 1; end
                    if (idx == 5 && !st_fired) begin st = 1; st_fired = 1; end
                end
                default: ;
            endcase
            step(sv, mr, cd, st, 0);
            if (mode == 3 && cd_fired && !err_chk && cd == 0) begin
                check("err_run", 32'(err), 32'd1);
                err_chk = 1;
            end
            if (mode == 2 && stall == 10 && !stall_chk) begin
                check("stall_full", 32'(q.size()), 32'd2);
                check("stall_sready", 32'(s_ready), 32'd0);
                stall_chk = 1;
            end
        end
        check("frame_tmo", 32'(n < 300), 32'd1);
        check("pix_count", 32'(pops), NPIX);
        if (mode == 0) begin
            check("first_lat", 32'(first_pop - first_push), 32'd1);
            check("throughput", 32'(last_pop - first_pop + 1), NPIX);
        end
        // Sitting in DRAIN until the core reports completion
        repeat (3) step(0, 1, 0, 0, 0);
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_sready", 32'(s_ready), 32'd0);
        check("early_done", 32'(fd_cnt), 32'd0);
        step(0, 1, 1, 0, 0);
        cd_cyc = cyc;
        repeat (4) step(0, 1, 0, 0, 0);
        check("frame_done", 32'(fd_cnt), 32'd1);
        check("done_lat", 32'(fd_cyc - cd_cyc >= 1 && fd_cyc - cd_cyc <= 2), 32'd1);
        check("idle_after", 32'(busy), 32'd0);
        check("err_end", 32'(err), 32'(mode == 3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_flags", 32'({s_ready, m_valid, m_sof, m_eol, m_eof, busy, frame_done, err}), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) step(0, 1, 0, 0, 0);
        check("idle_sready", 32'(s_ready), 32'd0);

        run_frame(0);   // full rate
        run_frame(1);   // random bubbles and back-pressure
        run_frame(2);   // long stall mid-row

        // Abort after 5 accepted pixels
        fd_cnt = 0;
        step(0, 1, 0, 1, 0);
        for (int n = 0; n < 50 && idx < 5; n++) step(1, int'($urandom_range(0, 1)), 0, 0, 0);
        check("abort_pre", 32'(idx), 32'd5);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        check("abort_flags", 32'({m_valid, busy, s_ready}), 32'd0);
        repeat (4) step(0, 1, 0, 0, 0);
        check("abort_nodone", 32'(fd_cnt), 32'd0);
        run_frame(0);   // fresh frame after abort starts at SOF

        run_frame(3);   // core_done in RUN sets err, stray start ignored

        // start+abort together in IDLE: stays idle, err kept
        step(0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        check("sa_idle", 32'({busy, s_ready}), 32'd0);
        check("sa_err", 32'(err), 32'd1);
        run_frame(0);   // start clears err

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
